// File: rtl/qpsk_mod_framer.sv
// QPSK framer/modulator front end: wraps a 24-bit payload as {HEADER, payload, CHK}
// and emits it MSB-first as 20 (I,Q) baseband symbols, each held SAMPLE cycles.
module qpsk_mod_framer #(
    parameter logic [7:0] HEADER = 8'hcc,
    parameter int         SAMPLE = 100,
    parameter int         GAP    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [23:0]        data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic signed [1:0]  sym_I,
    output logic signed [1:0]  sym_Q,
    output logic               sym_strobe,
    output logic               busy
);

    localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      samp_cnt, samp_nxt;
    logic [4:0]         sym_cnt, sym_nxt;
    logic [GW-1:0]      gap_cnt, gap_nxt;
    logic [39:0]        frame, frame_nxt;
    logic signed [1:0]  i_nxt, q_nxt;
    logic               strobe_nxt, busy_nxt;
    logic               armed;
    logic [7:0]         chk;
    logic [39:0]        word;
    logic               accept;
    logic               samp_last;

    function automatic logic signed [1:0] bit_level(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

    assign chk        = data_in[23:16] + data_in[15:8] + data_in[7:0];
    assign word       = {HEADER, data_in, chk};
    // armed keeps data_ready low while reset is held and for no longer than one edge after
    assign data_ready = armed && (state == ST_IDLE);
    assign accept     = data_valid && data_ready;
    assign samp_last  = (samp_cnt == SW'(SAMPLE - 1));

    always_comb begin
        state_nxt  = state;
        samp_nxt   = samp_cnt;
        sym_nxt    = sym_cnt;
        gap_nxt    = gap_cnt;
        frame_nxt  = frame;
        i_nxt      = 2'sb00;
        q_nxt      = 2'sb00;
        strobe_nxt = 1'b0;
        busy_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    // frame keeps only the bits not yet on air, left-aligned
                    state_nxt  = ST_SEND;
                    frame_nxt  = {word[37:0], 2'b00};
                    i_nxt      = bit_level(word[39]);
                    q_nxt      = bit_level(word[38]);
                    strobe_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    samp_nxt   = '0;
                    sym_nxt    = '0;
                end
            end
            ST_SEND: begin
                busy_nxt = 1'b1;
                i_nxt    = sym_I;
                q_nxt    = sym_Q;
                if (samp_last) begin
                    samp_nxt = '0;
                    if (sym_cnt == 5'd19) begin
                        i_nxt   = 2'sb00;
                        q_nxt   = 2'sb00;
                        gap_nxt = '0;
                        if (GAP == 0) begin
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                        end else begin
                            state_nxt = ST_GAP;
                        end
                    end else begin
                        sym_nxt    = sym_cnt + 5'd1;
                        i_nxt      = bit_level(frame[39]);
                        q_nxt      = bit_level(frame[38]);
                        frame_nxt  = {frame[37:0], 2'b00};
                        strobe_nxt = 1'b1;
                    end
                end else begin
                    samp_nxt = samp_cnt + SW'(1);
                end
            end
            ST_GAP: begin
                busy_nxt = 1'b1;
                if (samp_last) begin
                    samp_nxt = '0;
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state_nxt = ST_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        gap_nxt = gap_cnt + GW'(1);
                    end
                end else begin
                    samp_nxt = samp_cnt + SW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            samp_cnt   <= '0;
            sym_cnt    <= '0;
            gap_cnt    <= '0;
            frame      <= '0;
            sym_I      <= 2'sb00;
            sym_Q      <= 2'sb00;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            samp_cnt   <= samp_nxt;
            sym_cnt    <= sym_nxt;
            gap_cnt    <= gap_nxt;
            frame      <= frame_nxt;
            sym_I      <= i_nxt;
            sym_Q      <= q_nxt;
            sym_strobe <= strobe_nxt;
            busy       <= busy_nxt;
            armed      <= 1'b1;
        end
    end

endmodule
